// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared MMIO offsets and region decode type for the DMEM responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Word offsets counted down from the top of the data address space
    localparam int OFF_GPIO_OUT = 4;
    localparam int OFF_GPIO_IN  = 3;
    localparam int OFF_CYCLE    = 2;
    localparam int OFF_TCMP     = 1;

    typedef enum logic [2:0] {
        REG_RAM      = 3'd0,
        REG_GPIO_OUT = 3'd1,
        REG_GPIO_IN  = 3'd2,
        REG_CYCLE    = 3'd3,
        REG_TCMP     = 3'd4
    } region_t;

endpackage
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : mmio_timer
// Brief    : Free-running cycle counter with compare register and sticky irq.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_timer #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cycle_we,
    input  logic                 i_tcmp_we,
    input  logic [WORD_SIZE-1:0] i_wdata,
    output logic [WORD_SIZE-1:0] o_cycle,
    output logic [WORD_SIZE-1:0] o_tcmp,
    output logic                 o_irq
);

    logic [WORD_SIZE-1:0] r_cycle;
    logic [WORD_SIZE-1:0] r_tcmp;
    logic                 r_irq;
    logic                 w_match;

    // A zero compare value disables the timer
    assign w_match = (r_cycle == r_tcmp) && (r_tcmp != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle <= '0;
            r_tcmp  <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (i_cycle_we) begin
                r_cycle <= i_wdata;
            end else begin
                r_cycle <= r_cycle + WORD_SIZE'(1);
            end
            // Writing the compare acknowledges the irq, even on a match edge
            if (i_tcmp_we) begin
                r_tcmp <= i_wdata;
                r_irq  <= 1'b0;
            end else if (w_match) begin
                r_irq  <= 1'b1;
            end
        end
    end

    assign o_cycle = r_cycle;
    assign o_tcmp  = r_tcmp;
    assign o_irq   = r_irq;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Zero-latency word RAM with GPIO, cycle counter and timer MMIO.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int data_size  = 1024,
    parameter int word_size  = 32,
    parameter int gpio_width = 8
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic [$clog2(data_size)-1:0] daddr,
    input  logic [word_size-1:0]         ddata_w,
    input  logic                         d_rw,
    output logic [word_size-1:0]         ddata_r,
    input  logic [gpio_width-1:0]        gpio_in,
    output logic [gpio_width-1:0]        gpio_out,
    output logic                         irq
);

    localparam int c_aw = $clog2(data_size);
    localparam logic [c_aw-1:0] c_addr_gpio_out = c_aw'(data_size - OFF_GPIO_OUT);
    localparam logic [c_aw-1:0] c_addr_gpio_in  = c_aw'(data_size - OFF_GPIO_IN);
    localparam logic [c_aw-1:0] c_addr_cycle    = c_aw'(data_size - OFF_CYCLE);
    localparam logic [c_aw-1:0] c_addr_tcmp     = c_aw'(data_size - OFF_TCMP);

    logic [word_size-1:0]  r_mem [data_size];
    logic [gpio_width-1:0] r_gpio_out;
    logic [gpio_width-1:0] r_gpio_sync1;
    logic [gpio_width-1:0] r_gpio_sync2;
    logic [word_size-1:0]  w_cycle;
    logic [word_size-1:0]  w_tcmp;
    region_t               w_region;
    logic                  w_we;

    // Only a definite 1 writes; X/Z on d_rw degrades to a read
    assign w_we = (d_rw == 1'b1);

    always_comb begin
        w_region = REG_RAM;
        if (daddr == c_addr_gpio_out) w_region = REG_GPIO_OUT;
        if (daddr == c_addr_gpio_in)  w_region = REG_GPIO_IN;
        if (daddr == c_addr_cycle)    w_region = REG_CYCLE;
        if (daddr == c_addr_tcmp)     w_region = REG_TCMP;
    end

    always_ff @(posedge CLK) begin
        if (w_we && (w_region == REG_RAM)) begin
            r_mem[daddr] <= ddata_w;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_gpio_out   <= '0;
            r_gpio_sync1 <= '0;
            r_gpio_sync2 <= '0;
        end else begin
            r_gpio_sync1 <= gpio_in;
            r_gpio_sync2 <= r_gpio_sync1;
            if (w_we && (w_region == REG_GPIO_OUT)) begin
                r_gpio_out <= ddata_w[gpio_width-1:0];
            end
        end
    end

    mmio_timer #(
        .WORD_SIZE (word_size)
    ) u_timer (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .i_cycle_we (w_we && (w_region == REG_CYCLE)),
        .i_tcmp_we  (w_we && (w_region == REG_TCMP)),
        .i_wdata    (ddata_w),
        .o_cycle    (w_cycle),
        .o_tcmp     (w_tcmp),
        .o_irq      (irq)
    );

    always_comb begin
        ddata_r = r_mem[daddr];
        case (w_region)
            REG_GPIO_OUT: ddata_r = word_size'(r_gpio_out);
            REG_GPIO_IN:  ddata_r = word_size'(r_gpio_sync2);
            REG_CYCLE:    ddata_r = w_cycle;
            REG_TCMP:     ddata_r = w_tcmp;
            default:      ddata_r = r_mem[daddr];
        endcase
    end

    assign gpio_out = r_gpio_out;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Self-checking bench for dmem_responder with a read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int N  = 1024;
    localparam int AW = 10;

    logic          CLK;
    logic          RESET_N;
    logic [AW-1:0] daddr;
    logic [31:0]   ddata_w;
    logic          d_rw;
    logic [31:0]   ddata_r;
    logic [7:0]    gpio_in;
    logic [7:0]    gpio_out;
    logic          irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    dmem_responder #(
        .data_size  (N),
        .word_size  (32),
        .gpio_width (8)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .daddr    (daddr),
        .ddata_w  (ddata_w),
        .d_rw     (d_rw),
        .ddata_r  (ddata_r),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Queue the expected read, then compare when the output is sampled
    task automatic rd(input logic [AW-1:0] addr, input logic [31:0] exp,
                      input string tag, input bit at_neg);
        logic [31:0] e;
        string       t;
        daddr = addr;
        d_rw  = 1'b0;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        if (at_neg) @(negedge CLK);
        else #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, ddata_r, e);
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [31:0] data);
        daddr   = addr;
        ddata_w = data;
        d_rw    = 1'b1;
        @(posedge CLK);
        #1;
        d_rw    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        CLK     = 1'b0;
        RESET_N = 1'b0;
        daddr   = '0;
        ddata_w = '0;
        d_rw    = 1'b0;
        gpio_in = '0;

        // Reset state
        #1;
        chk("rst_gpio_out", 32'(gpio_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rd(AW'(N-4), 32'h0, "rst_rd_gpio_out", 1'b0);
        rd(AW'(N-2), 32'h0, "rst_rd_cycle", 1'b0);
        rd(AW'(N-1), 32'h0, "rst_rd_tcmp", 1'b0);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // RAM, including the last RAM word and same-cycle write visibility
        wr(AW'(5), 32'h1111_1111);
        wr(AW'(0), 32'h0000_00A0);
        wr(AW'(N-5), 32'hCAFE_F00D);
        daddr   = AW'(5);
        ddata_w = 32'hDEAD_BEEF;
        d_rw    = 1'b1;
        @(negedge CLK);
        chk("ram_write_cycle_old", ddata_r, 32'h1111_1111);
        @(posedge CLK);
        #1;
        d_rw = 1'b0;
        rd(AW'(5), 32'hDEAD_BEEF, "ram_rd5", 1'b1);
        rd(AW'(0), 32'h0000_00A0, "ram_rd0", 1'b1);
        rd(AW'(N-5), 32'hCAFE_F00D, "ram_rd_last", 1'b1);

        // GPIO
        wr(AW'(N-4), 32'h0000_01A5);
        chk("gpio_out_pin", 32'(gpio_out), 32'hA5);
        rd(AW'(N-4), 32'h0000_00A5, "gpio_out_rd", 1'b1);
        wr(AW'(N-3), 32'hFFFF_FFFF);
        rd(AW'(N-3), 32'h0, "gpio_in_wr_ignored", 1'b1);
        @(posedge CLK);
        #1;
        gpio_in = 8'h3C;
        rd(AW'(N-3), 32'h0, "gpio_in_0edge", 1'b1);
        rd(AW'(N-3), 32'h0, "gpio_in_1edge", 1'b1);
        rd(AW'(N-3), 32'h3C, "gpio_in_2edge", 1'b1);

        // Counter wrap
        wr(AW'(N-2), 32'hFFFF_FFFE);
        rd(AW'(N-2), 32'hFFFF_FFFE, "cyc_load", 1'b1);
        rd(AW'(N-2), 32'hFFFF_FFFF, "cyc_plus1", 1'b1);
        rd(AW'(N-2), 32'h0000_0000, "cyc_wrap", 1'b1);

        // Timer match, hold, clear, and disabled compare
        wr(AW'(N-1), 32'd20);
        wr(AW'(N-2), 32'd10);
        for (int j = 0; j < 12; j++) begin
            @(negedge CLK);
            chk($sformatf("irq_rise_%0d", j), 32'(irq), (j >= 11) ? 32'h1 : 32'h0);
        end
        for (int j = 0; j < 50; j++) begin
            @(negedge CLK);
            chk($sformatf("irq_hold_%0d", j), 32'(irq), 32'h1);
        end
        wr(AW'(N-1), 32'd0);
        chk("irq_clear", 32'(irq), 32'h0);
        wr(AW'(N-2), 32'hFFFF_FFFC);
        for (int j = 0; j < 10; j++) begin
            @(negedge CLK);
            chk($sformatf("irq_tcmp0_%0d", j), 32'(irq), 32'h0);
        end

        // Compare write on the exact match edge
        wr(AW'(N-1), 32'd40);
        wr(AW'(N-2), 32'd30);
        repeat (10) @(posedge CLK);
        #1;
        rd(AW'(N-2), 32'd40, "sim_cycle_at_match", 1'b0);
        wr(AW'(N-1), 32'h0000_5000);
        chk("sim_irq", 32'(irq), 32'h0);
        rd(AW'(N-1), 32'h0000_5000, "sim_tcmp", 1'b0);
        repeat (3) @(negedge CLK);
        chk("sim_irq_later", 32'(irq), 32'h0);

        // Asynchronous reset between edges
        wr(AW'(N-4), 32'h0000_00FF);
        wr(AW'(N-1), 32'd50);
        wr(AW'(N-2), 32'd48);
        repeat (3) @(posedge CLK);
        #1;
        chk("pre_rst_irq", 32'(irq), 32'h1);
        chk("pre_rst_gpio", 32'(gpio_out), 32'hFF);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("arst_irq", 32'(irq), 32'h0);
        chk("arst_gpio_out", 32'(gpio_out), 32'h0);
        rd(AW'(N-2), 32'h0, "arst_cycle", 1'b0);
        rd(AW'(5), 32'hDEAD_BEEF, "arst_ram_kept", 1'b0);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
